// File: rtl/dat_mem_copier.sv
// dat_mem_copier
//   Memory-access initiator for an 8-bit x 256 single-port data memory.
//   Copy mode moves LEN bytes from SRC to DST, one read then one write per byte, in forward order.
//   Fill mode writes a constant byte over LEN bytes starting at DST, one write per cycle.
//   A job is launched by a start pulse in IDLE and finishes with a one-cycle done pulse.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      job request, sampled only in IDLE
//   fill_mode  0 = copy, 1 = fill (latched at start)
//   src_addr   copy source base (latched at start)
//   dst_addr   destination base (latched at start)
//   len        byte count, 0..2**ADDR_W (latched at start)
//   fill_val   fill byte (latched at start)
//   mem_dout   memory read data, combinational from mem_addr
//   mem_addr   memory address
//   mem_din    memory write data
//   mem_wr_en  memory write enable
//   busy       high while reading or writing
//   done       one-cycle completion pulse
//   count      bytes written so far in the current job
module dat_mem_copier #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              fill_mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_val,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wr_en,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  count
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  count_q, count_d;

    // Low index bits only: address sums wrap at 2**ADDR_W.
    logic [ADDR_W-1:0] idx_lo;
    assign idx_lo = idx_q[ADDR_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            buf_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = fill_mode;
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = len;
                    fill_d  = fill_val;
                    idx_d   = '0;
                    count_d = '0;
                    if (len == '0) begin
                        state_d = StDone;
                    end else if (fill_mode) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                buf_d   = mem_dout;
                state_d = StWr;
            end
            StWr: begin
                idx_d   = idx_q + LEN_W'(1);
                count_d = count_q + LEN_W'(1);
                if (idx_q == len_q - LEN_W'(1)) begin
                    state_d = StDone;
                end else if (mode_q) begin
                    state_d = StWr;
                end else begin
                    state_d = StRd;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs: decoded from state and registered fields only.
    always_comb begin
        mem_addr  = '0;
        mem_din   = '0;
        mem_wr_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StRd: begin
                mem_addr = src_q + idx_lo;
                busy     = 1'b1;
            end
            StWr: begin
                mem_addr  = dst_q + idx_lo;
                mem_din   = mode_q ? fill_q : buf_q;
                mem_wr_en = 1'b1;
                busy      = 1'b1;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign count = count_q;

endmodule

// File: tb/tb_dat_mem_copier.sv
module tb_dat_mem_copier;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       fill_mode;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [8:0] len;
    logic [7:0] fill_val;
    logic [7:0] mem_dout;
    logic [7:0] mem_addr;
    logic [7:0] mem_din;
    logic       mem_wr_en;
    logic       busy;
    logic       done;
    logic [8:0] count;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       tb_we = 1'b0;
    logic [7:0] tb_addr = '0;
    logic [7:0] tb_data = '0;

    always #5 clk = ~clk;

    dat_mem_copier #(.DATA_W(8), .ADDR_W(8), .LEN_W(9)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .fill_mode (fill_mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .fill_val  (fill_val),
        .mem_dout  (mem_dout),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_wr_en (mem_wr_en),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    // Data memory: combinational read, synchronous write; bench preload port when idle.
    assign mem_dout = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_din;
        else if (tb_we) mem[tb_addr] <= tb_data;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic check_mem(input string name);
        int nbad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
        check(name, nbad, 0);
    endtask

    task automatic scramble_fields();
        fill_mode = 1'($urandom);
        src_addr  = 8'($urandom);
        dst_addr  = 8'($urandom);
        len       = 9'($urandom_range(1, 256));
        fill_val  = 8'($urandom);
    endtask

    // Runs one job and compares against a byte-by-byte forward-order model.
    task automatic run_job(input bit mode, input logic [7:0] src, input logic [7:0] dst,
                           input logic [8:0] ln, input logic [7:0] fv, input int exp_lat,
                           input string tag);
        logic [7:0] erd[$];
        logic [7:0] ewr[$];
        logic [7:0] rdq[$];
        logic [7:0] wrq[$];
        logic [7:0] a, w;
        int cyc = 0, got_lat = -1, wrs = 0, dones = 0, nbad = 0;
        bit poke = (exp_lat >= 4);
        for (int k = 0; k < int'(ln); k++) begin
            a = src + 8'(k);
            w = dst + 8'(k);
            if (mode) ref_mem[w] = fv;
            else begin
                erd.push_back(a);
                ref_mem[w] = ref_mem[a];
            end
            ewr.push_back(w);
        end
        @(negedge clk);
        start = 1'b1; fill_mode = mode; src_addr = src; dst_addr = dst; len = ln; fill_val = fv;
        @(posedge clk);
        #1 start = 1'b0;
        scramble_fields();
        while (cyc < 600 && got_lat < 0) begin
            @(negedge clk);
            cyc++;
            if (mem_wr_en) begin
                wrs++;
                wrq.push_back(mem_addr);
            end else if (busy) begin
                rdq.push_back(mem_addr);
            end
            if (done) begin
                dones++;
                got_lat = cyc;
            end
            if (poke && cyc == 2) begin
                scramble_fields();
                start = 1'b1;
            end
            if (poke && cyc == 3) start = 1'b0;
        end
        check({tag, " latency"}, got_lat, exp_lat);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check({tag, " done_pulses"}, dones, 1);
        check({tag, " count"}, int'(count), int'(ln));
        check({tag, " writes"}, wrs, int'(ln));
        check({tag, " reads"}, rdq.size(), erd.size());
        for (int k = 0; k < rdq.size() && k < erd.size(); k++) if (rdq[k] !== erd[k]) nbad++;
        for (int k = 0; k < wrq.size() && k < ewr.size(); k++) if (wrq[k] !== ewr[k]) nbad++;
        check({tag, " addr_order"}, nbad, 0);
        check_mem({tag, " mem"});
    endtask

    typedef struct {
        bit         mode;
        logic [7:0] src;
        logic [7:0] dst;
        logic [8:0] ln;
        logic [7:0] fv;
        int         lat;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int cyc, d1, d2;
        logic [7:0] old91;
        tbl[0] = '{1'b0, 8'h10, 8'h80, 9'd4,   8'h00, 9};
        tbl[1] = '{1'b1, 8'h00, 8'hF0, 9'd3,   8'hA5, 4};
        tbl[2] = '{1'b0, 8'hFE, 8'h40, 9'd4,   8'h00, 9};
        tbl[3] = '{1'b0, 8'h05, 8'h06, 9'd0,   8'h00, 1};
        tbl[4] = '{1'b0, 8'h20, 8'h21, 9'd3,   8'h00, 7};
        tbl[5] = '{1'b0, 8'h60, 8'h70, 9'd1,   8'h00, 3};
        tbl[6] = '{1'b1, 8'h00, 8'h00, 9'd256, 8'h5A, 257};

        reset = 1'b1; start = 1'b0; fill_mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_val = '0;
        #12;
        check("rst mem_addr", int'(mem_addr), 0);
        check("rst mem_din", int'(mem_din), 0);
        check("rst wr_en", int'(mem_wr_en), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst count", int'(count), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 256; i++) load(8'(i), 8'($urandom));
        load(8'h10, 8'h11); load(8'h11, 8'h22); load(8'h12, 8'h33); load(8'h13, 8'h44);
        load(8'h20, 8'h07);

        for (int i = 0; i < 7; i++) begin
            run_job(tbl[i].mode, tbl[i].src, tbl[i].dst, tbl[i].ln, tbl[i].fv, tbl[i].lat,
                    $sformatf("vec%0d", i));
            if (i == 0) begin
                check("vec0 dst_last", int'(mem[8'h83]), 'h44);
                check("vec0 src_kept", int'(mem[8'h10]), 'h11);
            end
            if (i == 4) check("vec4 overlap", int'(mem[8'h23]), 7);
        end

        for (int i = 0; i < 256; i++) load(8'(i), 8'($urandom));

        for (int n = 0; n < 20; n++) begin
            bit         m  = 1'($urandom);
            logic [8:0] ln = 9'($urandom_range(0, 40));
            int lat = (ln == 0) ? 1 : (m ? int'(ln) + 1 : 2 * int'(ln) + 1);
            run_job(m, 8'($urandom), 8'($urandom), ln, 8'($urandom), lat,
                    $sformatf("rnd%0d", n));
        end

        // Reset during the second write of a 4-byte copy.
        old91 = ref_mem[8'h91];
        @(negedge clk);
        start = 1'b1; fill_mode = 1'b0; src_addr = 8'h50; dst_addr = 8'h90; len = 9'd4;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; d1 = 0;
        while (cyc < 20 && d1 < 2) begin
            @(negedge clk);
            cyc++;
            if (mem_wr_en) d1++;
        end
        check("midrst reached_wr2", d1, 2);
        reset = 1'b1;
        #1;
        check("midrst wr_en", int'(mem_wr_en), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst mem_addr", int'(mem_addr), 0);
        check("midrst count", int'(count), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ref_mem[8'h90] = ref_mem[8'h50];
        check("midrst byte1", int'(mem[8'h91]), int'(old91));
        d2 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || busy) d2++;
        end
        check("midrst no_done", d2, 0);
        check_mem("midrst mem");

        // start held high through DONE relaunches on the following edge.
        ref_mem[8'h30] = 8'h3C; ref_mem[8'h31] = 8'h3C;
        @(negedge clk);
        start = 1'b1; fill_mode = 1'b1; dst_addr = 8'h30; len = 9'd2; fill_val = 8'h3C;
        @(posedge clk);
        cyc = 0; d1 = -1; d2 = -1;
        while (cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (d1 < 0) d1 = cyc;
                else if (d2 < 0) d2 = cyc;
            end
            if (cyc == 4) check("restart idle_gap", int'(busy), 0);
            if (cyc == 5) begin
                check("restart busy", int'(busy), 1);
                start = 1'b0;
            end
        end
        check("restart done1", d1, 3);
        check("restart done2", d2, 7);
        check_mem("restart mem");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
